// File: rtl/mem_responder.sv
// Memory responder for the 16-bit pipelined core: instruction and data memories,
// a host port for preload/readback, and start/stop run sequencing.
module mem_responder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] im_addr,
    input  logic                  im_rd,
    output logic [DATA_WIDTH-1:0] im_r_data,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic                  dm_rd,
    input  logic                  dm_wr,
    input  logic [DATA_WIDTH-1:0] dm_w_data,
    output logic [DATA_WIDTH-1:0] dm_r_data,
    output logic                  start,
    input  logic                  stop,
    input  logic                  host_sel,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic                  host_wr,
    input  logic                  host_rd,
    input  logic [DATA_WIDTH-1:0] host_w_data,
    output logic [DATA_WIDTH-1:0] host_r_data,
    output logic                  host_r_valid,
    input  logic                  host_go,
    output logic                  busy,
    output logic                  done,
    output logic                  host_err,
    output logic [CNT_WIDTH-1:0]  run_cycles
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic [DATA_WIDTH-1:0] im_mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] dm_mem_r [DEPTH];
    logic                  host_ok_s;
    logic                  host_wr_ok_s;
    logic                  host_rd_ok_s;
    logic [DATA_WIDTH-1:0] im_r_data_r;
    logic [DATA_WIDTH-1:0] dm_r_data_r;
    logic [DATA_WIDTH-1:0] host_r_data_r;
    logic                  host_r_valid_r;
    logic                  host_err_r;
    logic                  start_r;
    logic                  busy_r;
    logic                  done_r;
    logic [CNT_WIDTH-1:0]  run_cycles_r;

    // Host may only touch memory while the core is not running
    assign host_ok_s    = (state_r == IDLE) || (state_r == DONE);
    assign host_wr_ok_s = host_wr && host_ok_s;
    assign host_rd_ok_s = host_rd && host_ok_s;

    // Run sequencing next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (host_go) state_nx_s = START;
                else         state_nx_s = IDLE;
            end
            START: state_nx_s = RUN;
            RUN: begin
                if (stop) state_nx_s = DONE;
                else      state_nx_s = RUN;
            end
            DONE: begin
                if (host_go) state_nx_s = START;
                else         state_nx_s = DONE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State, status outputs, run counter and registered read ports
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            start_r        <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            run_cycles_r   <= '0;
            host_err_r     <= 1'b0;
            host_r_valid_r <= 1'b0;
            host_r_data_r  <= '0;
            im_r_data_r    <= '0;
            dm_r_data_r    <= '0;
        end else begin
            state_r        <= state_nx_s;
            start_r        <= (state_nx_s == START);
            busy_r         <= (state_nx_s == START) || (state_nx_s == RUN);
            done_r         <= (state_nx_s == DONE);
            if (state_nx_s == START) begin
                run_cycles_r <= '0;
            end else if ((state_r == RUN) && (run_cycles_r != '1)) begin
                run_cycles_r <= run_cycles_r + CNT_WIDTH'(1);
            end
            host_err_r     <= (host_wr || host_rd) && !host_ok_s;
            host_r_valid_r <= host_rd_ok_s;
            if (host_rd_ok_s) begin
                host_r_data_r <= host_sel ? dm_mem_r[host_addr] : im_mem_r[host_addr];
            end
            if (im_rd) begin
                im_r_data_r <= im_mem_r[im_addr];
            end
            // A core write in the same cycle suppresses the data read
            if (dm_rd && !dm_wr) begin
                dm_r_data_r <= dm_mem_r[dm_addr];
            end
        end
    end

    // Memory writes; arrays keep their contents across rst
    always_ff @(posedge clk) begin
        if (host_wr_ok_s && !host_sel) begin
            im_mem_r[host_addr] <= host_w_data;
        end
        if (host_wr_ok_s && host_sel) begin
            dm_mem_r[host_addr] <= host_w_data;
        end else if (dm_wr) begin
            dm_mem_r[dm_addr] <= dm_w_data;
        end
    end

    assign im_r_data    = im_r_data_r;
    assign dm_r_data    = dm_r_data_r;
    assign host_r_data  = host_r_data_r;
    assign host_r_valid = host_r_valid_r;
    assign host_err     = host_err_r;
    assign start        = start_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign run_cycles   = run_cycles_r;
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory responder for the 16-bit pipelined processor: owns the 256×16 instruction memory and the 256×16 data memory, and serves the core's `im_*` and `dm_*` request ports. Also drives the core's `start` input and watches its `stop` output. A host port preloads memory, launches a run and reads results back. It sits beside the processor top as the target end of its memory and start/stop interfaces.

## Interface
- `DATA_WIDTH`, 16, memory word width
- `ADDR_WIDTH`, 8, word address width; each memory holds 2^ADDR_WIDTH words
- `CNT_WIDTH`, 16, run-cycle counter width
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `im_addr` input ADDR_WIDTH: instruction fetch address from core
- `im_rd` input 1: instruction read enable
- `im_r_data` output DATA_WIDTH: instruction word to core
- `dm_addr` input ADDR_WIDTH: data address from core
- `dm_rd` input 1: data read enable
- `dm_wr` input 1: data write enable
- `dm_w_data` input DATA_WIDTH: data write word
- `dm_r_data` output DATA_WIDTH: data read word to core
- `start` output 1: one-cycle run pulse to core
- `stop` input 1: core halted
- `host_sel` input 1: 0 selects IM, 1 selects DM
- `host_addr` input ADDR_WIDTH: host word address
- `host_wr`, `host_rd` input 1: host write / read strobes
- `host_w_data` input DATA_WIDTH: host write word
- `host_r_data` output DATA_WIDTH: host read word
- `host_r_valid` output 1: host_r_data valid (one-cycle pulse)
- `host_go` input 1: request a run
- `busy` output 1: run in progress (START or RUN)
- `done` output 1: core stopped, results readable
- `host_err` output 1: one-cycle pulse, host access rejected
- `run_cycles` output CNT_WIDTH: cycles spent in RUN

## Operation
- FSM states: IDLE, START, RUN, DONE.
  - IDLE → START on `host_go`.
  - START → RUN unconditionally after 1 cycle.
  - RUN → DONE on `stop`.
  - DONE → START on `host_go`.
  - `rst` in any state → IDLE.
- Outputs by state:
  - `start` = 1 only in START.
  - `busy` = 1 in START and RUN.
  - `done` = 1 only in DONE.
- Host access is accepted only in IDLE and DONE.
  - `host_wr` writes `host_w_data` to the memory selected by `host_sel`.
  - `host_rd` returns the selected word.
  - `host_wr` and `host_rd` together: the write is performed and the read returns the old word.
  - Any host strobe in START or RUN is dropped: no memory change, `host_err` pulses on the next cycle, `host_r_valid` stays 0.
- Core reads and writes are serviced in every state. Outside RUN the core is expected to be idle; no gating is applied.
- Core data port:
  - `dm_wr` writes `dm_w_data` to `DM[dm_addr]`.
  - `dm_rd` and `dm_wr` together: the write wins and `dm_r_data` holds its previous value.
- Host and core writes to DM in the same cycle cannot collide: host writes are only accepted outside RUN. If both do occur in IDLE or DONE, the host write wins.
- `run_cycles`:
  - Cleared on entry to START.
  - Increments every RUN cycle, including the cycle `stop` is sampled.
  - Saturates at all-ones.
  - Holds its value in DONE and IDLE.
- Memory arrays are not reset. Contents survive `rst`.

## Timing
- Reads are registered, 1-cycle latency.
  - `im_rd` at cycle N → `im_r_data` = `IM[im_addr]` at N+1.
  - `dm_rd` follows the same rule.
  - `host_rd` → `host_r_data` plus a `host_r_valid` pulse at N+1.
- Read data holds its last value while the read enable is low.
- Write at cycle N is visible to a read issued at N+1.
- `host_go` sampled at N in IDLE/DONE → `start` = 1 during N+1 → `busy` stays 1 from N+1.
- `stop` sampled at N in RUN → `done` = 1 and `busy` = 0 at N+1.
- `host_go` in START or RUN is ignored, with no `host_err`.
- `stop` outside RUN is ignored.
- Reset values (cycle after `rst`): state IDLE; `im_r_data`, `dm_r_data`, `host_r_data` = 0; `start`, `busy`, `done`, `host_r_valid`, `host_err` = 0; `run_cycles` = 0.
- `rst` mid-RUN aborts the run. The FSM is in IDLE on the next cycle and no `done` is produced.

## Test plan
- Preload and readback: in IDLE, host writes IM[0x05]=0xA5C3 and DM[0xFF]=0x1234, then reads both → `host_r_valid` pulses one cycle after each read with 0xA5C3 and 0x1234; no `host_err`.
- Fetch latency: in RUN, `im_rd`=1 with `im_addr`=0x05 at cycle N → `im_r_data`=0xA5C3 at N+1. `im_rd`=0 at N+1 → value held at N+2.
- Data write/read:
  - `dm_wr` with `dm_addr`=0x10, `dm_w_data`=0xBEEF at N, then `dm_rd` on 0x10 at N+1 → `dm_r_data`=0xBEEF at N+2.
  - Simultaneous `dm_rd`+`dm_wr` → `dm_r_data` unchanged.
- Run sequencing: `host_go` in IDLE → one-cycle `start`. Assert `stop` after 20 RUN cycles → `done`=1, `busy`=0, `run_cycles`=20. A second `host_go` from DONE → `run_cycles` cleared, new `start` pulse.
- Rejection: `host_wr` to DM[0x10]=0x0000 during RUN → `host_err` pulse one cycle later. A host read of DM[0x10] after `done` returns 0xBEEF.
- Reset mid-run: assert `rst` during RUN → next cycle IDLE with all outputs at reset values. A host read of IM[0x05] still returns 0xA5C3.
